// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one word over a valid/ready load, one bit per falling clk edge.
// Build option PIPO_TX_PARITY_EN appends one even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | waiting for load_valid; load_ready high
// SHIFT  | data bits on sout, count = index (1-based) of the bit currently on the line
// PARITY | parity bit on sout (PIPO_TX_PARITY_EN builds only)
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PIPO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sout_q, sout_d;
  logic               sout_valid_q, sout_valid_d;
  logic               done_q, done_d;
`ifdef PIPO_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
`ifdef PIPO_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d      = SHIFT;
          count_d      = CNT_W'(1);
          sout_valid_d = 1'b1;
`ifdef PIPO_TX_PARITY_EN
          parity_d     = ^din;
`endif
          // shift_q keeps only the bits still to be sent, aligned so the next one sits at the output end
          if (MSB_FIRST) begin
            sout_d  = din[WIDTH-1];
            shift_d = din << 1;
          end else begin
            sout_d  = din[0];
            shift_d = din >> 1;
          end
        end
      end
      SHIFT: begin
        if (count_q == CNT_W'(WIDTH)) begin
`ifdef PIPO_TX_PARITY_EN
          state_d      = PARITY;
          sout_d       = parity_q;
          sout_valid_d = 1'b1;
`else
          state_d      = IDLE;
          done_d       = 1'b1;
`endif
        end else begin
          count_d      = count_q + 1'b1;
          sout_valid_d = 1'b1;
          if (MSB_FIRST) begin
            sout_d  = shift_q[WIDTH-1];
            shift_d = shift_q << 1;
          end else begin
            sout_d  = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef PIPO_TX_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      count_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
`ifdef PIPO_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: LSB-first and MSB-first instances driven in parallel, checked against a
// frame-queue model; honours PIPO_TX_PARITY_EN when the bench is built with it.
module tb_piso_tx;

  localparam int W = 4;
`ifdef PIPO_TX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;

  logic sout0, sv0, busy0, done0, ready0;
  logic sout1, sv1, busy1, done1, ready1;

  int n_checks = 0;
  int n_fail   = 0;

  // model: frame bits for each bit order, position of the bit on the line (-1 when idle)
  bit q0[$];
  bit q1[$];
  int pos    = -1;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(ready0), .sout(sout0), .sout_valid(sv0), .busy(busy0), .done(done0)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(ready1), .sout(sout1), .sout_valid(sv1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [W-1:0] d);
    q0.delete();
    q1.delete();
    for (int i = 0; i < W; i++) begin
      q0.push_back(d[i]);
      q1.push_back(d[W-1-i]);
    end
`ifdef PIPO_TX_PARITY_EN
    q0.push_back(($countones(d) % 2) == 1);
    q1.push_back(($countones(d) % 2) == 1);
`endif
  endtask

  task automatic model_edge(input bit lv, input logic [W-1:0] d);
    if (pos < 0) begin
      m_done = 1'b0;
      if (lv) begin
        build_frame(d);
        pos = 0;
      end
    end else begin
      pos++;
      if (pos == q0.size()) begin
        pos    = -1;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    pos    = -1;
    m_done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    bit act;
    act = (pos >= 0);
    check({tag, ":sout_lsb"},  sout0,  act ? q0[pos] : 1'b0);
    check({tag, ":sout_msb"},  sout1,  act ? q1[pos] : 1'b0);
    check({tag, ":valid_lsb"}, sv0,    act);
    check({tag, ":valid_msb"}, sv1,    act);
    check({tag, ":busy_lsb"},  busy0,  act);
    check({tag, ":busy_msb"},  busy1,  act);
    check({tag, ":ready_lsb"}, ready0, !act);
    check({tag, ":ready_msb"}, ready1, !act);
    check({tag, ":done_lsb"},  done0,  m_done);
    check({tag, ":done_msb"},  done1,  m_done);
  endtask

  task automatic step(input string tag, input bit lv, input logic [W-1:0] d);
    load_valid = lv;
    din        = d;
    @(negedge clk);
    #1;
    model_edge(lv, d);
    check_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":sout"},  sout0,  1'b0);
    check({tag, ":valid"}, sv0,    1'b0);
    check({tag, ":done"},  done0,  1'b0);
    check({tag, ":busy"},  busy0,  1'b0);
    check({tag, ":ready"}, ready0, 1'b1);
    check({tag, ":busy_msb"}, busy1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] e_lsb, e_msb, wa, wb;

    // async reset with no clock edge
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    rst = 1'b1;
    model_reset();

    step("idle0", 1'b0, 4'h0);
    step("idle1", 1'b0, 4'h7);

    // directed 1011: LSB-first 1,1,0,1 / MSB-first 1,0,1,1
    e_lsb = 4'b1011;
    e_msb = 4'b1101;
    step("w1011", 1'b1, 4'b1011);
    check("w1011_lsb_b0", sout0, e_lsb[0]);
    check("w1011_msb_b0", sout1, e_msb[0]);
    for (int k = 1; k < W; k++) begin
      step("w1011", 1'b0, 4'($urandom));
      check("w1011_lsb_bit", sout0, e_lsb[k]);
      check("w1011_msb_bit", sout1, e_msb[k]);
    end
`ifdef PIPO_TX_PARITY_EN
    step("w1011_par", 1'b0, 4'h0);
    check("w1011_parity", sout0, 1'b1);
    check("w1011_parity_valid", sv0, 1'b1);
`endif
    step("w1011_done", 1'b0, 4'h0);
    check("w1011_done", done0, 1'b1);
    check("w1011_done_valid", sv0, 1'b0);
    step("w1011_after", 1'b0, 4'h0);
    check("w1011_done_cleared", done0, 1'b0);

`ifdef PIPO_TX_PARITY_EN
    step("w0011", 1'b1, 4'b0011);
    for (int k = 1; k < W; k++) step("w0011", 1'b0, 4'h0);
    step("w0011_par", 1'b0, 4'h0);
    check("w0011_parity", sout0, 1'b0);
    step("w0011_done", 1'b0, 4'h0);
    check("w0011_done", done0, 1'b1);
`endif

    // back-to-back with load_valid held high: A then 5, second accept on the done cycle
    wa = 4'hA;
    wb = 4'h5;
    step("b2b_a", 1'b1, wa);
    check("b2b_a_bit0", sout0, wa[0]);
    for (int k = 1; k < FRAME; k++) begin
      step("b2b_a", 1'b1, wb);
      if (k < W) check("b2b_a_bit", sout0, wa[k]);
    end
    step("b2b_gap", 1'b1, wb);
    check("b2b_gap_done", done0, 1'b1);
    check("b2b_gap_ready", ready0, 1'b1);
    step("b2b_b", 1'b1, wb);
    check("b2b_b_accept", busy0, 1'b1);
    check("b2b_b_bit0", sout0, wb[0]);
    check("b2b_b_done_low", done0, 1'b0);
    load_valid = 1'b0;
    for (int k = 1; k < W; k++) begin
      step("b2b_b", 1'b0, 4'h0);
      check("b2b_b_bit", sout0, wb[k]);
    end
    for (int k = W; k <= FRAME; k++) step("b2b_b_end", 1'b0, 4'h0);
    check("b2b_b_done", done0, 1'b1);
    step("b2b_idle", 1'b0, 4'h0);

    // load_valid pulse and din change mid-frame are ignored
    step("ign_acc", 1'b1, 4'b0110);
    step("ign_pulse", 1'b1, 4'b1001);
    check("ign_bit1", sout0, 1'b1);
    for (int k = 2; k <= FRAME; k++) step("ign_run", 1'b0, 4'hF);
    check("ign_done", done0, 1'b1);
    step("ign_idle", 1'b0, 4'hF);
    check("ign_no_extra", sv0, 1'b0);

    // reset after two bits: immediate, no done pulse
    step("rst_acc", 1'b1, 4'hC);
    step("rst_b1", 1'b0, 4'h0);
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst_mid");
    check_all("rst_mid");
    @(negedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
    e_lsb = 4'b0011;
    step("w3", 1'b1, 4'h3);
    check("w3_bit0", sout0, e_lsb[0]);
    for (int k = 1; k < W; k++) begin
      step("w3", 1'b0, 4'h0);
      check("w3_bit", sout0, e_lsb[k]);
    end
    for (int k = W; k <= FRAME; k++) step("w3_end", 1'b0, 4'h0);
    check("w3_done", done0, 1'b1);

    // random traffic with occasional async reset pulses between edges
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rnd_rst");
        rst = 1'b1;
      end
      step("rnd", ($urandom_range(0, 3) != 0), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
